// File: rtl/mux_n_to_1_skid.sv
// N-to-1 channel multiplexer feeding a two-entry skid buffer.
// The selected channel is captured on accept; words drain in acceptance order.
// in_ready and out_valid come straight from the state register, so neither
// handshake has a combinational path from the opposite side.
//
// state    | meaning
// ---------+--------------------------------------------
// EMPTY    | nothing buffered; out_valid=0, in_ready=1
// ONE      | main holds the head word; skid unused
// TWO      | main holds the head, skid holds the next word; in_ready=0
module mux_n_to_1_skid #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 flush,
    output logic                 sel_err
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // Widened by one bit so the compare also works when N is a power of two.
    localparam logic [SEL_W:0] N_LIMIT = N[SEL_W:0];

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             sel_err_q, sel_err_d;

    logic [WIDTH-1:0] cap_word;
    logic             sel_bad;
    logic             accept;
    logic             pop;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = (state_q != ST_TWO);
    assign out_data  = main_q;
    assign sel_err   = sel_err_q;

    assign accept  = in_valid && in_ready;
    assign pop     = out_valid && out_ready;
    assign sel_bad = ({1'b0, sel} >= N_LIMIT);

    // Channel select; an out-of-range sel captures an all-zero word.
    always_comb begin
        cap_word = '0;
        for (int k = 0; k < N; k++) begin
            if ({1'b0, sel} == k[SEL_W:0]) begin
                cap_word = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and data-path decisions; flush drops both handshakes.
    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        skid_d    = skid_q;
        sel_err_d = sel_err_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            if (accept && sel_bad) begin
                sel_err_d = 1'b1;
            end
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = cap_word;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    case ({accept, pop})
                        2'b10: begin
                            skid_d  = cap_word;
                            state_d = ST_TWO;
                        end
                        2'b11: begin
                            main_d  = cap_word;
                        end
                        2'b01: begin
                            state_d = ST_EMPTY;
                        end
                        default: begin
                            state_d = ST_ONE;
                        end
                    endcase
                end
                ST_TWO: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and storage registers; reset zeroes everything so out_data is never X.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            sel_err_q <= sel_err_d;
        end
    end

endmodule

// File: tb/tb_mux_n_to_1_skid.sv
// Bench for mux_n_to_1_skid: an N=4/WIDTH=32 instance and an N=3/WIDTH=8
// instance, each followed by a queue-based reference model.
module tb_mux_n_to_1_skid;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: N=4, WIDTH=32
    logic [127:0] a_in_data;
    logic [1:0]   a_sel;
    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic         a_flush, a_reset, a_sel_err;
    logic [31:0]  a_out_data;

    // Instance B: N=3, WIDTH=8
    logic [23:0]  b_in_data;
    logic [1:0]   b_sel;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic         b_flush, b_reset, b_sel_err;
    logic [7:0]   b_out_data;

    mux_n_to_1_skid #(.WIDTH(32), .N(4)) dut_a (
        .clk(clk), .reset(a_reset), .in_data(a_in_data), .sel(a_sel),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .flush(a_flush),
        .sel_err(a_sel_err)
    );

    mux_n_to_1_skid #(.WIDTH(8), .N(3)) dut_b (
        .clk(clk), .reset(b_reset), .in_data(b_in_data), .sel(b_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .flush(b_flush),
        .sel_err(b_sel_err)
    );

    // Reference models: queues of words in acceptance order.
    logic [31:0] qa[$];
    logic [31:0] a_word;
    bit          a_zero = 1'b1;
    logic [7:0]  qb[$];
    logic [7:0]  b_word;
    bit          b_bad;
    bit          b_zero = 1'b1;
    bit          b_err_exp = 1'b0;

    typedef struct {
        bit          iv;
        int          sel;
        logic [31:0] word;
        bit          ordy;
        bit          ov;
        bit          ir;
        bit          chk_d;
        logic [31:0] od;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive_a(input bit iv, input int s, input logic [31:0] w,
                           input bit ordy, input bit fl, input bit rs);
        for (int k = 0; k < 4; k++) a_in_data[k*32 +: 32] = $urandom;
        a_in_data[s*32 +: 32] = w;
        a_sel       = 2'(s);
        a_word      = w;
        a_in_valid  = iv;
        a_out_ready = ordy;
        a_flush     = fl;
        a_reset     = rs;
    endtask

    task automatic step_a();
        bit acc, pp;
        logic [31:0] dummy;
        acc = a_in_valid && (qa.size() < 2);
        pp  = a_out_ready && (qa.size() > 0);
        @(posedge clk);
        if (a_reset) begin
            qa.delete();
            a_zero = 1'b1;
        end else if (a_flush) begin
            qa.delete();
        end else begin
            if (pp) dummy = qa.pop_front();
            if (acc) begin
                qa.push_back(a_word);
                a_zero = 1'b0;
            end
        end
        #1;
        check("a_out_valid", 32'(a_out_valid), 32'(qa.size() > 0));
        check("a_in_ready", 32'(a_in_ready), 32'(qa.size() < 2));
        if (qa.size() > 0) check("a_out_data", a_out_data, qa[0]);
        else if (a_zero) check("a_out_data_zero", a_out_data, 32'h0);
        check("a_sel_err", 32'(a_sel_err), 32'h0);
    endtask

    task automatic drive_b(input bit iv, input int s, input logic [7:0] w,
                           input bit ordy, input bit fl, input bit rs);
        for (int k = 0; k < 3; k++) b_in_data[k*8 +: 8] = 8'($urandom);
        if (s < 3) b_in_data[s*8 +: 8] = w;
        b_sel       = 2'(s);
        b_bad       = (s >= 3);
        b_word      = (s < 3) ? w : 8'h00;
        b_in_valid  = iv;
        b_out_ready = ordy;
        b_flush     = fl;
        b_reset     = rs;
    endtask

    task automatic step_b();
        bit acc, pp;
        logic [7:0] dummy;
        acc = b_in_valid && (qb.size() < 2);
        pp  = b_out_ready && (qb.size() > 0);
        @(posedge clk);
        if (b_reset) begin
            qb.delete();
            b_zero    = 1'b1;
            b_err_exp = 1'b0;
        end else if (b_flush) begin
            qb.delete();
        end else begin
            if (pp) dummy = qb.pop_front();
            if (acc) begin
                qb.push_back(b_word);
                b_zero = 1'b0;
                if (b_bad) b_err_exp = 1'b1;
            end
        end
        #1;
        check("b_out_valid", 32'(b_out_valid), 32'(qb.size() > 0));
        check("b_in_ready", 32'(b_in_ready), 32'(qb.size() < 2));
        if (qb.size() > 0) check("b_out_data", 32'(b_out_data), 32'(qb[0]));
        else if (b_zero) check("b_out_data_zero", 32'(b_out_data), 32'h0);
        check("b_sel_err", 32'(b_sel_err), 32'(b_err_exp));
    endtask

    initial begin
        // Hand-computed expectations, sampled after each edge, starting from EMPTY.
        tbl[0]  = '{1, 2, 32'hDEADBEEF, 1, 1, 1, 1, 32'hDEADBEEF};
        tbl[1]  = '{0, 0, 32'h0,        1, 0, 1, 0, 32'h0};
        tbl[2]  = '{1, 0, 32'h00000011, 0, 1, 1, 1, 32'h00000011};
        tbl[3]  = '{1, 1, 32'h00000022, 0, 1, 0, 1, 32'h00000011};
        tbl[4]  = '{1, 3, 32'h00000033, 0, 1, 0, 1, 32'h00000011};
        tbl[5]  = '{0, 0, 32'h0,        1, 1, 1, 1, 32'h00000022};
        tbl[6]  = '{0, 0, 32'h0,        1, 0, 1, 0, 32'h0};
        tbl[7]  = '{1, 3, 32'h00000044, 1, 1, 1, 1, 32'h00000044};
        tbl[8]  = '{1, 1, 32'h00000055, 1, 1, 1, 1, 32'h00000055};
        tbl[9]  = '{0, 0, 32'h0,        0, 1, 1, 1, 32'h00000055};
        tbl[10] = '{0, 0, 32'h0,        1, 0, 1, 0, 32'h0};

        drive_a(0, 0, 32'h0, 0, 0, 1);
        drive_b(0, 0, 8'h0, 0, 0, 1);
        step_a();
        step_a();
        drive_b(0, 0, 8'h0, 0, 0, 0);

        // Reset state of A
        drive_a(0, 0, 32'h0, 0, 0, 0);
        check("rst_out_valid", 32'(a_out_valid), 32'h0);
        check("rst_in_ready", 32'(a_in_ready), 32'h1);
        check("rst_out_data", a_out_data, 32'h0);
        check("rst_sel_err", 32'(a_sel_err), 32'h0);

        // Table vectors
        for (int i = 0; i < 11; i++) begin
            drive_a(tbl[i].iv, tbl[i].sel, tbl[i].word, tbl[i].ordy, 0, 0);
            step_a();
            check($sformatf("tbl%0d_ov", i), 32'(a_out_valid), 32'(tbl[i].ov));
            check($sformatf("tbl%0d_ir", i), 32'(a_in_ready), 32'(tbl[i].ir));
            if (tbl[i].chk_d) check($sformatf("tbl%0d_od", i), a_out_data, tbl[i].od);
        end

        // Streaming: one word per cycle with sel cycling 0..3
        for (int i = 0; i < 100; i++) begin
            drive_a(1, i % 4, $urandom, 1, 0, 0);
            step_a();
        end
        drive_a(0, 0, 32'h0, 1, 0, 0);
        step_a();
        check("stream_drained", 32'(a_out_valid), 32'h0);

        // Flush in TWO together with in_valid and out_ready
        drive_a(1, 0, 32'hA0A0A0A0, 0, 0, 0); step_a();
        drive_a(1, 3, 32'hB1B1B1B1, 0, 0, 0); step_a();
        check("two_before_flush", 32'(a_in_ready), 32'h0);
        drive_a(1, 2, 32'hC2C2C2C2, 1, 1, 0); step_a();
        check("flush_ov", 32'(a_out_valid), 32'h0);
        check("flush_ir", 32'(a_in_ready), 32'h1);
        drive_a(0, 0, 32'h0, 1, 0, 0); step_a();
        check("flush_no_accept", 32'(a_out_valid), 32'h0);

        // Reset in TWO
        drive_a(1, 1, 32'h12345678, 0, 0, 0); step_a();
        drive_a(1, 2, 32'h9ABCDEF0, 0, 0, 0); step_a();
        drive_a(1, 0, 32'h0BADF00D, 1, 0, 1); step_a();
        check("rst_two_ov", 32'(a_out_valid), 32'h0);
        check("rst_two_od", a_out_data, 32'h0);
        check("rst_two_ir", 32'(a_in_ready), 32'h1);
        drive_a(0, 0, 32'h0, 0, 0, 0); step_a();

        // N=3 instance: out-of-range sel, sticky error, reset clears it
        step_b();
        drive_b(1, 3, 8'hFF, 0, 0, 0); step_b();
        check("b_bad_od", 32'(b_out_data), 32'h0);
        check("b_bad_err", 32'(b_sel_err), 32'h1);
        drive_b(1, 1, 8'hA5, 1, 0, 0); step_b();
        check("b_after_od", 32'(b_out_data), 32'hA5);
        drive_b(1, 2, 8'h5A, 1, 1, 0); step_b();
        check("b_flush_err", 32'(b_sel_err), 32'h1);
        drive_b(1, 0, 8'h3C, 1, 0, 0); step_b();
        drive_b(0, 0, 8'h0, 1, 0, 1); step_b();
        check("b_rst_err", 32'(b_sel_err), 32'h0);
        drive_b(1, 2, 8'h77, 1, 0, 0); step_b();
        check("b_sel2_od", 32'(b_out_data), 32'h77);
        check("b_sel2_err", 32'(b_sel_err), 32'h0);
        drive_b(0, 0, 8'h0, 1, 0, 0); step_b();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_n_to_1_skid.md
MUX_N_TO_1_SKID -- requirements
Module: mux_n_to_1_skid

Interface
REQ-001 Parameter WIDTH, default 32: data width of each channel and of the output, in bits.
REQ-002 Parameter N, default 4: number of input channels, N >= 2; localparam SEL_W = $clog2(N).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data  input  N*WIDTH  flattened channels; channel k is bits [k*WIDTH +: WIDTH].
REQ-006 sel  input  SEL_W  channel select, sampled with in_data on accept.
REQ-007 in_valid  input  1  upstream offers (in_data, sel).
REQ-008 in_ready  output  1  block can accept this cycle.
REQ-009 out_data  output  WIDTH  selected word at head of buffer.
REQ-010 out_valid  output  1  out_data holds a valid word.
REQ-011 out_ready  input  1  downstream consumes out_data this cycle.
REQ-012 flush  input  1  synchronous discard of all buffered words.
REQ-013 sel_err  output  1  sticky flag: an accepted sel was >= N.

Function
REQ-014 Accept = in_valid && in_ready; pop = out_valid && out_ready; both evaluated on the same edge.
REQ-015 Captured word = channel sel of in_data when sel < N; all-zero when sel >= N, and sel_err is set on that edge.
REQ-016 Storage is two registers: main (drives out_data) and skid; FSM states EMPTY, ONE (main valid), TWO (main and skid valid).
REQ-017 out_valid = (state != EMPTY); in_ready = (state != TWO); both driven directly from state registers, with no combinational path from in_valid/out_ready.
REQ-018 EMPTY: accept loads main and goes to ONE; with no accept, stays in EMPTY.
REQ-019 ONE: accept without pop loads skid and goes to TWO; accept with pop reloads main and stays in ONE; pop without accept goes to EMPTY; with neither, holds.
REQ-020 TWO: pop moves skid to main and goes to ONE; with no pop, holds; no accept is possible because in_ready = 0.
REQ-021 Latency: from an accept in EMPTY, out_valid = 1 with the captured word on the next cycle; throughput is one word per cycle while out_ready = 1.
REQ-022 Words leave in acceptance order; none is dropped or duplicated.
REQ-023 out_data is stable and unchanged while out_valid = 1 and out_ready = 0.
REQ-024 flush = 1: next state is EMPTY regardless of in_valid or out_ready, and any accept or pop on that edge is ignored; sel_err is unaffected.
REQ-025 Register contents while invalid are don't-care, but out_data shall not be X after reset.

Reset
REQ-026 reset = 1 on an edge forces state EMPTY, main = 0, skid = 0, and sel_err = 0, overriding flush, accept, and pop.
REQ-027 After reset: out_valid = 0, in_ready = 1, out_data = 0, sel_err = 0.
REQ-028 Reset asserted mid-operation (state ONE or TWO) discards all buffered words within one edge.

Verification
REQ-029 N=4, WIDTH=32; reset, then accept ch2 = 0xDEADBEEF with sel = 2 and out_ready = 1 -> next cycle out_valid = 1, out_data = 0xDEADBEEF; following cycle out_valid = 0.
REQ-030 out_ready = 0; accept A = 0x11 (sel 0) then B = 0x22 (sel 1) -> in_ready = 0 after the second accept, out_data = 0x11 held; raise out_ready -> 0x11 then 0x22 on consecutive cycles, then in_ready = 1.
REQ-031 Continuous in_valid and out_ready with sel cycling 0..3 over 100 words -> one word per cycle, order preserved, in_ready never drops.
REQ-032 N=3, accept sel = 3 -> out_data = 0, sel_err = 1; sel_err stays 1 through subsequent valid traffic and flush; reset clears it.
REQ-033 State TWO, assert flush together with in_valid and out_ready -> next cycle out_valid = 0, in_ready = 1, and no word is accepted.
REQ-034 State TWO, assert reset with flush = 0 -> next cycle out_valid = 0, out_data = 0, in_ready = 1.
